// File: rtl/bits_number_decoder_if.sv
// Request/result bundle for bits_number_decoder: the master issues a literal
// and a start strobe, the slave returns the decoded value and status.
interface bits_number_decoder_if;
  logic [79:0] encoded_number;
  logic        decodeNumber;
  logic [63:0] decodedNumber;
  logic [6:0]  bitsToShift;
  logic        decodeDone;
  logic        decodeBusy;
  logic        decodeError;

  modport master (
    output encoded_number,
    output decodeNumber,
    input  decodedNumber,
    input  bitsToShift,
    input  decodeDone,
    input  decodeBusy,
    input  decodeError
  );

  modport slave (
    input  encoded_number,
    input  decodeNumber,
    output decodedNumber,
    output bitsToShift,
    output decodeDone,
    output decodeBusy,
    output decodeError
  );
endinterface

// File: rtl/bits_number_decoder.sv
// Variable-length literal decoder: 5-bit groups (continuation flag + nibble), up to 16 groups.
// Define BITS_NUMDEC_FAST_EN to decode every group combinationally in the start cycle.
module bits_number_decoder (
  input  logic                  clk,
  input  logic                  resetB,
  bits_number_decoder_if.slave  bus_if
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] decodedNumber_q, decodedNumber_d;
  logic [6:0]  bitsToShift_q, bitsToShift_d;
  logic        decodeError_q, decodeError_d;
  logic [79:0] encIn;

  assign encIn = bus_if.encoded_number;

  // State and the result registers share one reset domain; results only move on entry to DONE.
  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) begin
      state_q         <= IDLE;
      decodedNumber_q <= '0;
      bitsToShift_q   <= '0;
      decodeError_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      decodedNumber_q <= decodedNumber_d;
      bitsToShift_q   <= bitsToShift_d;
      decodeError_q   <= decodeError_d;
    end
  end

`ifdef BITS_NUMDEC_FAST_EN

  logic [63:0] fastAcc;
  logic [6:0]  fastBits;
  logic        fastErr;
  logic        fastFound;

  // Walk the groups in stream order; everything after the terminator is ignored.
  always_comb begin
    fastAcc   = '0;
    fastBits  = '0;
    fastErr   = 1'b1;
    fastFound = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (!fastFound) begin
        fastAcc  = {fastAcc[59:0], encIn[78 - 5*k -: 4]};
        fastBits = fastBits + 7'd5;
        if (!encIn[79 - 5*k]) begin
          fastFound = 1'b1;
          fastErr   = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    decodedNumber_d = decodedNumber_q;
    bitsToShift_d   = bitsToShift_q;
    decodeError_d   = decodeError_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus_if.decodeNumber) begin
          state_d         = DONE;
          decodedNumber_d = fastAcc;
          bitsToShift_d   = fastBits;
          decodeError_d   = fastErr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`else

  logic [79:0] shift_q, shift_d;
  logic [63:0] acc_q, acc_d;
  logic [3:0]  count_q, count_d;
  logic        groupFlag;
  logic [3:0]  groupNibble;
  logic [63:0] accNext;
  logic [6:0]  groupsUsed;
  logic [6:0]  groupBits;

  assign groupFlag   = shift_q[79];
  assign groupNibble = shift_q[78:75];
  assign accNext     = {acc_q[59:0], groupNibble};
  assign groupsUsed  = {3'b000, count_q} + 7'd1;
  assign groupBits   = (groupsUsed << 2) + groupsUsed;

  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) begin
      shift_q <= '0;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      shift_q <= shift_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

  // One group per DECODE cycle; the literal is captured at start so later input changes are invisible.
  always_comb begin
    state_d         = state_q;
    shift_d         = shift_q;
    acc_d           = acc_q;
    count_d         = count_q;
    decodedNumber_d = decodedNumber_q;
    bitsToShift_d   = bitsToShift_q;
    decodeError_d   = decodeError_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus_if.decodeNumber) begin
          state_d = DECODE;
          shift_d = encIn;
          acc_d   = '0;
          count_d = '0;
        end
      end
      DECODE: begin
        acc_d   = accNext;
        count_d = count_q + 4'd1;
        shift_d = {shift_q[74:0], 5'b00000};
        if (!groupFlag) begin
          state_d         = DONE;
          decodedNumber_d = accNext;
          bitsToShift_d   = groupBits;
          decodeError_d   = 1'b0;
        end else if (count_q == 4'd15) begin
          state_d         = DONE;
          decodedNumber_d = accNext;
          bitsToShift_d   = 7'd80;
          decodeError_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`endif

  assign bus_if.decodedNumber = decodedNumber_q;
  assign bus_if.bitsToShift   = bitsToShift_q;
  assign bus_if.decodeError   = decodeError_q;
  assign bus_if.decodeDone    = (state_q == DONE);
  assign bus_if.decodeBusy    = (state_q == DECODE);

endmodule

// File: tb/tb_bits_number_decoder.sv
// Scoreboard bench for bits_number_decoder: directed literals push expected results,
// a negedge monitor pops them on decodeDone and checks value, size, error and arrival cycle.
module tb_bits_number_decoder;

  typedef struct {
    logic [63:0] value;
    logic [6:0]  bits;
    logic        err;
    int          doneCycle;
    string       name;
  } sbEntry_t;

`ifdef BITS_NUMDEC_FAST_EN
  localparam logic EXP_BUSY = 1'b0;
`else
  localparam logic EXP_BUSY = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        resetB;
  int          cycleCount = 0;
  int          compared = 0;
  int          mismatched = 0;
  sbEntry_t    sbQueue[$];
  logic [63:0] heldVal  = '0;
  logic [6:0]  heldBits = '0;
  logic        heldErr  = 1'b0;
  logic [79:0] v29, v30, v31, v32, v5g, vZero, vOne;
  logic [95:0] rnd;

  bits_number_decoder_if bus ();

  bits_number_decoder dut (
    .clk    (clk),
    .resetB (resetB),
    .bus_if (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  function automatic int latency(input int groups);
`ifdef BITS_NUMDEC_FAST_EN
    return 1 + 0 * groups;
`else
    return groups + 1;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cycleCount);
    end
  endtask

  // Called away from a clock edge; the start is sampled on the next rising edge.
  task automatic applyStimulus(input logic [79:0] enc, input logic [63:0] expVal,
                               input logic [6:0] expBits, input logic expErr,
                               input int groups, input string name);
    sbEntry_t e;
    bus.encoded_number = enc;
    bus.decodeNumber   = 1'b1;
    e.value     = expVal;
    e.bits      = expBits;
    e.err       = expErr;
    e.doneCycle = cycleCount + latency(groups);
    e.name      = name;
    sbQueue.push_back(e);
    @(posedge clk);
    #1;
    bus.decodeNumber   = 1'b0;
    bus.encoded_number = ~enc;
    checkOutput({name, "_busy"}, 64'(bus.decodeBusy), 64'(EXP_BUSY));
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sbQueue.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (sbQueue.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain_timeout: %0d results still pending after %0d cycles", sbQueue.size(), budget);
      sbQueue.delete();
    end
  endtask

  task automatic waitForDone(input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.decodeDone) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("done_seen", 64'(seen), 64'd1);
  endtask

  // Monitor: results are compared on decodeDone and must stay frozen on every other cycle.
  always @(negedge clk) begin
    sbEntry_t e;
    if (!resetB) begin
      heldVal  = '0;
      heldBits = '0;
      heldErr  = 1'b0;
    end else if (bus.decodeDone) begin
      if (sbQueue.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_done: got decodeDone=1 expected 0 at cycle %0d", cycleCount);
      end else begin
        e = sbQueue.pop_front();
        checkOutput({e.name, "_value"}, bus.decodedNumber, e.value);
        checkOutput({e.name, "_bits"}, 64'(bus.bitsToShift), 64'(e.bits));
        checkOutput({e.name, "_err"}, 64'(bus.decodeError), 64'(e.err));
        checkOutput({e.name, "_cycle"}, 64'(cycleCount), 64'(e.doneCycle));
        checkOutput({e.name, "_busy_at_done"}, 64'(bus.decodeBusy), 64'd0);
        heldVal  = e.value;
        heldBits = e.bits;
        heldErr  = e.err;
      end
    end else begin
      checkOutput("hold_value", bus.decodedNumber, heldVal);
      checkOutput("hold_bits", 64'(bus.bitsToShift), 64'(heldBits));
      checkOutput("hold_err", 64'(bus.decodeError), 64'(heldErr));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    v29   = {15'b10111_11110_00101, 65'd0};
    rnd   = {$urandom(), $urandom(), $urandom()};
    v30   = {5'b00001, rnd[74:0]};
    v5g   = {25'b11010_10011_11100_10001_01111, 55'd0};
    vZero = {10'b10000_00000, {70{1'b1}}};
    vOne  = {5'b01111, {75{1'b1}}};
    for (int k = 0; k < 16; k++) begin
      v31[79 - 5*k -: 5] = (k < 15) ? 5'b11111 : 5'b01111;
      v32[79 - 5*k -: 5] = {1'b1, 4'(k + 1)};
    end

    resetB             = 1'b1;
    bus.decodeNumber   = 1'b0;
    bus.encoded_number = '0;
    #2 resetB = 1'b0;
    #1;
    checkOutput("reset_value", bus.decodedNumber, 64'd0);
    checkOutput("reset_bits", 64'(bus.bitsToShift), 64'd0);
    checkOutput("reset_done", 64'(bus.decodeDone), 64'd0);
    checkOutput("reset_busy", 64'(bus.decodeBusy), 64'd0);
    checkOutput("reset_err", 64'(bus.decodeError), 64'd0);
    repeat (2) @(posedge clk);
    #1 resetB = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(v29, 64'h7E5, 7'd15, 1'b0, 3, "three_groups");
    waitDrain(40);
    applyStimulus(v30, 64'h1, 7'd5, 1'b0, 1, "single_group");
    waitDrain(40);
    applyStimulus(v31, 64'hFFFF_FFFF_FFFF_FFFF, 7'd80, 1'b0, 16, "sixteen_ones");
    waitDrain(40);
    applyStimulus(v32, 64'h1234_5678_9ABC_DEF0, 7'd80, 1'b1, 16, "no_terminator");
    waitDrain(40);
    applyStimulus(v5g, 64'hA3C1F, 7'd25, 1'b0, 5, "five_groups");
    waitDrain(40);
    applyStimulus(vZero, 64'h0, 7'd10, 1'b0, 2, "zero_two_groups");
    waitDrain(40);
    applyStimulus(vOne, 64'hF, 7'd5, 1'b0, 1, "trailing_ignored");
    waitDrain(40);

`ifndef BITS_NUMDEC_FAST_EN
    applyStimulus(v29, 64'h7E5, 7'd15, 1'b0, 3, "ignore_first");
    @(posedge clk);
    #1;
    bus.encoded_number = {5'b00001, 75'd0};
    bus.decodeNumber   = 1'b1;
    @(posedge clk);
    #1 bus.decodeNumber = 1'b0;
    waitDrain(40);
    repeat (6) @(posedge clk);
    #1;
`endif

    applyStimulus(v5g, 64'hA3C1F, 7'd25, 1'b0, 5, "b2b_first");
    waitForDone(40);
    applyStimulus(v29, 64'h7E5, 7'd15, 1'b0, 3, "b2b_second");
    waitDrain(40);

    // Abort a decode with reset two cycles after the start cycle.
    applyStimulus(v29, 64'h7E5, 7'd15, 1'b0, 3, "aborted");
    @(posedge clk);
    #1 resetB = 1'b0;
    sbQueue.delete();
    #1;
    checkOutput("abort_value", bus.decodedNumber, 64'd0);
    checkOutput("abort_bits", 64'(bus.bitsToShift), 64'd0);
    checkOutput("abort_done", 64'(bus.decodeDone), 64'd0);
    checkOutput("abort_busy", 64'(bus.decodeBusy), 64'd0);
    checkOutput("abort_err", 64'(bus.decodeError), 64'd0);
    repeat (2) @(posedge clk);
    #1 resetB = 1'b1;
    repeat (8) begin
      @(negedge clk);
      checkOutput("post_reset_busy", 64'(bus.decodeBusy), 64'd0);
    end
    #1;
    applyStimulus(v30, 64'h1, 7'd5, 1'b0, 1, "after_reset");
    waitDrain(40);

    repeat (20) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
